pbvi_decision_scheduler: RTL and testbench

Scheduler that shares one PBVI decision engine (belief · alpha argmax unit) among N belief requesters. It accepts belief vectors over per-requester valid/ready, arbitrates round-robin, launches the engine with a one-cycle start pulse and holds the belief stable. It then returns the chosen action, tagged with the requester id, over a valid/ready response channel. A watchdog bounds engine latency; on expiry the block returns a default action with an error flag.

---
 rtl/pbvi_decision_scheduler.sv | 123 ++++++++++++
 tb/tb_pbvi_decision_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pbvi_decision_scheduler.sv
// Shares one PBVI decision engine among N requesters: round-robin accept,
// one-cycle launch, watchdog-bounded wait, then a tagged valid/ready response.
module pbvi_decision_scheduler #(
    parameter int         N              = 4,
    parameter int         TIMEOUT        = 16,
    parameter logic [1:0] DEFAULT_ACTION = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*32-1:0]      req_belief,
    output logic                 eng_start,
    output logic [15:0]          eng_belief0,
    output logic [15:0]          eng_belief1,
    input  logic                 eng_done,
    input  logic [1:0]           eng_action,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [1:0]           rsp_action,
    output logic                 rsp_error
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] idx;
    logic           grant_hit;
    logic [CW-1:0]  wd_cnt;
    logic           wd_expire;

    // First pending requester after the last one served, wrapping.
    always_comb begin
        grant     = last_grant;
        grant_hit = 1'b0;
        idx       = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(last_grant) + i) % N);
            if (!grant_hit && req_valid[idx]) begin
                grant_hit = 1'b1;
                grant     = idx;
            end
        end
    end

    // Expiry is judged on the count this WAIT cycle would reach.
    assign wd_expire = (int'(wd_cnt) + 1) >= TIMEOUT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done || wd_expire) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= IDW'(N - 1);
            eng_belief0 <= '0;
            eng_belief1 <= '0;
            rsp_id      <= '0;
            rsp_action  <= '0;
            rsp_error   <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        eng_belief0 <= req_belief[int'(grant)*32 +: 16];
                        eng_belief1 <= req_belief[int'(grant)*32 + 16 +: 16];
                        rsp_id      <= grant;
                    end
                end
                LAUNCH: wd_cnt <= '0;
                WAIT: begin
                    if (wd_cnt != CW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
                    if (eng_done) begin
                        rsp_action <= eng_action;
                        rsp_error  <= 1'b0;
                    end else if (wd_expire) begin
                        rsp_action <= DEFAULT_ACTION;
                        rsp_error  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) last_grant <= rsp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pbvi_decision_scheduler.sv
// Directed bench for pbvi_decision_scheduler; responses are checked by a
// monitor against a queue of hand-computed expectations.
module tb_pbvi_decision_scheduler;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_belief;
    logic         eng_start;
    logic [15:0]  eng_belief0;
    logic [15:0]  eng_belief1;
    logic         eng_done;
    logic [1:0]   eng_action;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [1:0]   rsp_action;
    logic         rsp_error;

    typedef struct {
        logic [1:0] id;
        logic [1:0] act;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t e;
    int   checks = 0;
    int   failures = 0;
    int   starts = 0;
    int   s0;
    logic [1:0] rr_act [6] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    pbvi_decision_scheduler #(.N(4), .TIMEOUT(16), .DEFAULT_ACTION(2'b00)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_belief(req_belief),
        .eng_start(eng_start), .eng_belief0(eng_belief0), .eng_belief1(eng_belief1),
        .eng_done(eng_done), .eng_action(eng_action),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_action(rsp_action), .rsp_error(rsp_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (eng_start) starts <= starts + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({req_ready, eng_start, eng_belief0, eng_belief1,
                    rsp_valid, rsp_id, rsp_action, rsp_error});
    endfunction

    // Scoreboard monitor: every accepted response must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected id=%0d action=%0d error=%0d required=none",
                             rsp_id, rsp_action, rsp_error);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_action", 64'(rsp_action), 64'(e.act));
                    chk("rsp_error", 64'(rsp_error), 64'(e.err));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_belief = '0;
        eng_done = 1'b0; eng_action = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            req_belief[32*i +: 32] = {16'(16'hA000 + i), 16'(16'h1000 * (i + 1))};

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outputs", outs(), 64'd0);
            tick();
        end

        // Round-robin with every requester pending and an immediate engine
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back('{2'(j % 4), rr_act[j], 1'b0});
            @(negedge clk);
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (j % 4)));
            tick();
            @(negedge clk);
            chk("rr_start", 64'(eng_start), 64'd1);
            chk("rr_belief0", 64'(eng_belief0), 64'(16'h1000 * (j % 4 + 1)));
            tick();
            eng_done = 1'b1; eng_action = rr_act[j];
            tick();
            eng_done = 1'b0;
            @(negedge clk);
            chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            tick();
        end
        req_valid = '0;

        // Single job, minimum latency
        req_belief[95:64] = {16'hC000, 16'h4000};
        req_valid = 4'b0100;
        s0 = starts;
        exp_q.push_back('{2'd2, 2'd3, 1'b0});
        @(negedge clk);
        chk("sj_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("sj_start", 64'(eng_start), 64'd1);
        chk("sj_belief0", 64'(eng_belief0), 64'h4000);
        chk("sj_belief1", 64'(eng_belief1), 64'hC000);
        tick();
        eng_done = 1'b1; eng_action = 2'd3;
        @(negedge clk);
        chk("sj_no_rsp_c2", 64'(rsp_valid), 64'd0);
        tick();
        eng_done = 1'b0;
        @(negedge clk);
        chk("sj_rsp_c3", 64'(rsp_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("sj_one_start", 64'(starts - s0), 64'd1);
        chk("sj_belief_hold", 64'(eng_belief0), 64'h4000);
        tick();

        // Watchdog timeout with a silent engine
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        exp_q.push_back('{2'd1, 2'd0, 1'b1});
        @(negedge clk);
        chk("to_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        for (int c = 2; c <= 17; c++) tick();
        @(negedge clk);
        chk("to_no_rsp_c17", 64'(rsp_valid), 64'd0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("to_rsp_c18", 64'(rsp_valid), 64'd1);
        chk("to_rsp_error", 64'(rsp_error), 64'd1);
        tick();
        rsp_ready = 1'b0;
        eng_done = 1'b1; eng_action = 2'd3;
        s0 = starts;
        tick();
        eng_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("to_late_done_ignored", 64'({rsp_valid, eng_start}), 64'd0);
            tick();
        end
        chk("to_no_restart", 64'(starts - s0), 64'd0);

        // Backpressure with stray done pulses in LAUNCH and RESP
        req_valid = 4'b1000;
        s0 = starts;
        exp_q.push_back('{2'd3, 2'd2, 1'b0});
        @(negedge clk);
        chk("bp_grant", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        eng_done = 1'b1; eng_action = 2'd1;
        tick();
        eng_done = 1'b0;
        @(negedge clk);
        chk("bp_no_rsp_c2", 64'(rsp_valid), 64'd0);
        tick();
        eng_done = 1'b1; eng_action = 2'd2;
        @(negedge clk);
        chk("bp_no_rsp_c3", 64'(rsp_valid), 64'd0);
        tick();
        eng_done = 1'b0;
        req_valid = 4'hF;
        for (int c = 4; c < 14; c++) begin
            eng_done = (c == 6);
            eng_action = 2'd0;
            @(negedge clk);
            chk("bp_hold_fields", 64'({rsp_valid, rsp_id, rsp_action, rsp_error}), 64'({1'b1, 2'd3, 2'd2, 1'b0}));
            chk("bp_hold_ready_start", 64'({req_ready, eng_start}), 64'd0);
            tick();
        end
        eng_done = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("bp_one_start", 64'(starts - s0), 64'd1);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_next", 64'(req_ready), 64'h4);

        // Reset during WAIT aborts the job and restores requester-0 priority
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_outputs", outs(), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        req_valid = 4'hF;
        exp_q.push_back('{2'd0, 2'd1, 1'b0});
        @(negedge clk);
        chk("rstmid_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("rstmid_start", 64'(eng_start), 64'd1);
        chk("rstmid_belief0", 64'(eng_belief0), 64'h1000);
        tick();
        eng_done = 1'b1; eng_action = 2'd1; rsp_ready = 1'b1;
        tick();
        eng_done = 1'b0;
        @(negedge clk);
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
        rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
